// File: rtl/sort4_pkg.sv
// Shared types and step table for the sequential 4-element sorter.
package sort4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SORT4_STEPS = 5;

    // Pair visited at each network step: (0,1) (2,3) (0,2) (1,3) (1,2)
    localparam logic [1:0] STEP_LO [SORT4_STEPS] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd1};
    localparam logic [1:0] STEP_HI [SORT4_STEPS] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd2};

    function automatic logic [1:0] step_lo(input logic [2:0] step);
        return (int'(step) < SORT4_STEPS) ? STEP_LO[step] : 2'd0;
    endfunction

    function automatic logic [1:0] step_hi(input logic [2:0] step);
        return (int'(step) < SORT4_STEPS) ? STEP_HI[step] : 2'd1;
    endfunction

endpackage

// File: rtl/sort4_cmpx.sv
// Combinational compare-exchange; ascending by default, descending
// when SORT4_SEQ_DESCEND_EN is defined.
module sort4_cmpx #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_swapped
);

    logic w_swap;

`ifdef SORT4_SEQ_DESCEND_EN
    assign w_swap = (i_x < i_y);
`else
    assign w_swap = (i_x > i_y);
`endif

    // o_lo goes back to the lower-index register, o_hi to the higher one
    assign o_lo      = w_swap ? i_y : i_x;
    assign o_hi      = w_swap ? i_x : i_y;
    assign o_swapped = w_swap;

endmodule

// File: rtl/sort4_seq.sv
// Multi-cycle 4-element sorter: one shared compare-exchange unit stepped
// through a 5-step network. Optional macro: SORT4_SEQ_DESCEND_EN.
module sort4_seq
    import sort4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_ra,
    output logic [WIDTH-1:0] o_rb,
    output logic [WIDTH-1:0] o_rc,
    output logic [WIDTH-1:0] o_rd,
    output logic [2:0]       o_swap_cnt,
    output logic             o_busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_step;
    logic [2:0]       r_swap_cnt;
    logic [WIDTH-1:0] r_val [4];
    logic             r_alive;

    logic [1:0]       w_lo_idx;
    logic [1:0]       w_hi_idx;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_hi;
    logic             w_swapped;
    logic             w_accept;
    logic             w_last_step;

    assign w_lo_idx    = step_lo(r_step);
    assign w_hi_idx    = step_hi(r_step);
    assign w_last_step = (r_step == 3'(SORT4_STEPS - 1));

    // r_alive keeps in_ready low while reset is held and for no longer
    assign o_in_ready  = (r_state == ST_IDLE) && r_alive;
    assign w_accept    = o_in_ready && i_in_valid;
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state == ST_SORT);
    assign o_swap_cnt  = r_swap_cnt;
    assign o_ra        = r_val[0];
    assign o_rb        = r_val[1];
    assign o_rc        = r_val[2];
    assign o_rd        = r_val[3];

    sort4_cmpx #(.WIDTH(WIDTH)) u_cmpx (
        .i_x       (r_val[w_lo_idx]),
        .i_y       (r_val[w_hi_idx]),
        .o_lo      (w_lo),
        .o_hi      (w_hi),
        .o_swapped (w_swapped)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)    w_state_nxt = ST_SORT;
            ST_SORT: if (w_last_step) w_state_nxt = ST_DONE;
            ST_DONE: if (i_out_ready) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val      <= '{default: '0};
            r_step     <= 3'd0;
            r_swap_cnt <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_val[0]   <= i_a;
                        r_val[1]   <= i_b;
                        r_val[2]   <= i_c;
                        r_val[3]   <= i_d;
                        r_step     <= 3'd0;
                        r_swap_cnt <= 3'd0;
                    end
                end
                ST_SORT: begin
                    r_val[w_lo_idx] <= w_lo;
                    r_val[w_hi_idx] <= w_hi;
                    r_step          <= r_step + 3'd1;
                    if (w_swapped) r_swap_cnt <= r_swap_cnt + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_seq.sv
// Directed bench for sort4_seq with a scoreboard of network-model results.
module tb_sort4_seq;

    localparam int W = 4;

    typedef struct packed {
        logic [3:0][W-1:0] r;
        logic [2:0]        sw;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] ra, rb, rc, rd;
    logic [2:0]   swap_cnt;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t q [$];

    always #5 clk = ~clk;

    sort4_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_c         (c),
        .i_d         (d),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_ra        (ra),
        .o_rb        (rb),
        .o_rc        (rc),
        .o_rd        (rd),
        .o_swap_cnt  (swap_cnt),
        .o_busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] va, vb, vc, vd);
        int         lo [5] = '{0, 2, 0, 1, 1};
        int         hi [5] = '{1, 3, 2, 3, 2};
        logic [W-1:0] v [4];
        logic [W-1:0] t;
        bit         sw;
        exp_t       e;
        v[0] = va; v[1] = vb; v[2] = vc; v[3] = vd;
        e.sw = 3'd0;
        for (int s = 0; s < 5; s++) begin
`ifdef SORT4_SEQ_DESCEND_EN
            sw = v[lo[s]] < v[hi[s]];
`else
            sw = v[lo[s]] > v[hi[s]];
`endif
            if (sw) begin
                t = v[lo[s]]; v[lo[s]] = v[hi[s]]; v[hi[s]] = t;
                e.sw = e.sw + 3'd1;
            end
        end
        for (int i = 0; i < 4; i++) e.r[i] = v[i];
        return e;
    endfunction

    task automatic check_result(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_q_empty"}, 32'd1, 32'd0);
            return;
        end
        e = q.pop_front();
        chk({tag, "_ra"}, 32'(ra), 32'(e.r[0]));
        chk({tag, "_rb"}, 32'(rb), 32'(e.r[1]));
        chk({tag, "_rc"}, 32'(rc), 32'(e.r[2]));
        chk({tag, "_rd"}, 32'(rd), 32'(e.r[3]));
        chk({tag, "_swaps"}, 32'(swap_cnt), 32'(e.sw));
    endtask

    // Drive one operand set, check latency, optional in_valid toggling
    // during SORT, optional DONE backpressure, then the output handshake.
    task automatic run_set(input string tag, input logic [W-1:0] va, vb, vc, vd,
                           input int hold, input bit toggle);
        int   lat;
        exp_t e;
        @(negedge clk);
        a = va; b = vb; c = vc; d = vd;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        q.push_back(model(va, vb, vc, vd));
        #1 in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            if (toggle) begin
                in_valid = k[0];
                a = ~va;
                chk({tag, "_sort_in_ready"}, 32'(in_ready), 32'd0);
                chk({tag, "_sort_busy"}, 32'(busy), 32'd1);
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        if (lat == 0) begin
            out_ready = 1'b1;
            repeat (3) @(posedge clk);
            void'(q.pop_front());
            return;
        end
        if (hold > 0) begin
            e = q[0];
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_vals"}, 32'({ra, rb, rc, rd}), 32'(e.r[0] << 12 | e.r[1] << 8 | e.r[2] << 4 | e.r[3]));
            end
            out_ready = 1'b1;
        end
        check_result(tag);
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vals", 32'({ra, rb, rc, rd}), 32'd0);
        chk("rst_swaps", 32'(swap_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

        run_set("basic",  4'd9, 4'd3, 4'd14, 4'd1, 0, 1'b0);
        run_set("sorted", 4'd1, 4'd2, 4'd3,  4'd4, 0, 1'b0);
        run_set("revrs",  4'd4, 4'd3, 4'd2,  4'd1, 0, 1'b0);
        run_set("dups",   4'd7, 4'd7, 4'd2,  4'd7, 0, 1'b1);
        run_set("bkpr",   4'd15, 4'd0, 4'd8, 4'd15, 10, 1'b0);

        // Abort mid-SORT at step 2
        @(negedge clk);
        a = 4'd12; b = 4'd6; c = 4'd3; d = 4'd10;
        in_valid = 1'b1;
        @(posedge clk);
        q.push_back(model(a, b, c, d));
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("abort_busy_rst", 32'(busy), 32'd0);
        chk("abort_vals", 32'({ra, rb, rc, rd}), 32'd0);
        chk("abort_swaps", 32'(swap_cnt), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("abort_rel_ready", 32'(in_ready), 32'd1);
        run_set("after",  4'd5, 4'd0, 4'd8, 4'd2, 0, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
